// File: rtl/jh_fifo_pkg.sv
// Shared defaults and helpers for the multi-channel register FIFO.
package jh_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_NUM_CH     = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jh_reg_fifo_lane.sv
// Single-channel register FIFO: push/pop/clear with occupancy, full/empty and head.
module jh_reg_fifo_lane
    import jh_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // Clear wins over both push and pop; a full lane ignores pushes.
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    // Next pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are meaningless once occupancy is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/jh_mc_reg_fifo.sv
// Multi-channel register FIFO with a round-robin read arbiter that locks its
// grant while a presented entry waits for out_ready.
module jh_mc_reg_fifo
    import jh_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  AF_LEVEL   = FIFO_DEPTH - 1,
    localparam int CHW        = $clog2(NUM_CH),
    localparam int CW         = cnt_width(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CHW-1:0]         in_ch,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [CHW-1:0]         out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear,
    output logic [NUM_CH*CW-1:0]   count,
    output logic [NUM_CH-1:0]      almost_full
);

    logic [NUM_CH-1:0]     push_w, pop_w, full_w, empty_w;
    logic [DATA_WIDTH-1:0] head_w  [NUM_CH];
    logic [CW-1:0]         count_w [NUM_CH];

    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0] grant_q, grant_d;
    logic           lock_q, lock_d;
    logic [CHW-1:0] scan_g, grant;
    logic           scan_found;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign push_w[c] = in_valid && in_ready && (in_ch == CHW'(c));
        assign pop_w[c]  = out_valid && out_ready && (grant == CHW'(c));

        jh_reg_fifo_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (clear),
            .push     (push_w[c]),
            .push_data(in_data),
            .pop      (pop_w[c]),
            .head     (head_w[c]),
            .count    (count_w[c]),
            .full     (full_w[c]),
            .empty    (empty_w[c])
        );

        assign count[c*CW +: CW] = count_w[c];
        assign almost_full[c]    = (count_w[c] >= CW'(AF_LEVEL));
    end

    assign in_ready  = !full_w[in_ch];
    assign grant     = lock_q ? grant_q : scan_g;
    assign out_valid = lock_q || scan_found;
    assign out_ch    = grant;
    assign out_data  = head_w[grant];

    // Round-robin scan: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        scan_found = 1'b0;
        scan_g     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!scan_found && !empty_w[CHW'(cand)]) begin
                scan_found = 1'b1;
                scan_g     = CHW'(cand);
            end
        end
    end

    // Arbiter next state: advance past the read channel, hold grant while stalled.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        lock_d   = lock_q;
        if (clear) begin
            rr_ptr_d = '0;
            grant_d  = '0;
            lock_d   = 1'b0;
        end else if (out_valid && out_ready) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end else if (out_valid) begin
            lock_d  = 1'b1;
            grant_d = grant;
        end
    end

    // Arbiter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
        end
    end

endmodule

// File: tb/tb_jh_mc_reg_fifo.sv
// Bench for jh_mc_reg_fifo: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_jh_mc_reg_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int NCH = 4;
    localparam int AF = 3;
    localparam int CW = 3;

    logic           clk;
    logic           rstn;
    logic [DW-1:0]  in_data;
    logic [1:0]     in_ch;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
    logic           clear;
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0] almost_full;

    int total = 0;
    int bad = 0;

    // Reference model: one queue per channel, round-robin pointer, held grant.
    logic [DW-1:0] mq [NCH][$];
    int  rr = 0;
    bit  lk = 0;
    int  lk_ch = 0;

    jh_mc_reg_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .AF_LEVEL(AF)
    ) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_ch(in_ch),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .clear(clear), .count(count), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(count[c*CW +: CW]);
    endfunction

    function automatic void model_grant(output bit v, output int g);
        int c;
        v = 0;
        g = 0;
        if (lk) begin
            v = 1;
            g = lk_ch;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                c = (rr + i) % NCH;
                if (!v && mq[c].size() > 0) begin
                    v = 1;
                    g = c;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        rr = 0;
        lk = 0;
        lk_ch = 0;
    endtask

    task automatic drive(input bit v, input int ch, input int d, input bit ord, input bit clr);
        in_valid  = v;
        in_ch     = 2'(ch);
        in_data   = 8'(d);
        out_ready = ord;
        clear     = clr;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic half();
        bit v;
        int g;
        @(negedge clk);
        model_grant(v, g);
        chk("out_valid", out_valid, v);
        if (v) begin
            chk("out_ch", out_ch, g);
            chk("out_data", out_data, mq[g][0]);
        end
        chk("in_ready", in_ready, mq[in_ch].size() < DEPTH);
        for (int c = 0; c < NCH; c++) begin
            chk("count", cnt_of(c), mq[c].size());
            chk("almost_full", almost_full[c], mq[c].size() >= AF);
        end
    endtask

    // Advance one clock and apply the same transaction to the model.
    task automatic tick();
        bit v, rd, wr;
        int g;
        model_grant(v, g);
        rd = v && out_ready;
        wr = in_valid && (mq[in_ch].size() < DEPTH);
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else begin
            if (rd) begin
                void'(mq[g].pop_front());
                rr = (g + 1) % NCH;
                lk = 0;
            end else if (v) begin
                lk = 1;
                lk_ch = g;
            end
            if (wr) mq[in_ch].push_back(in_data);
        end
        #1;
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit ord, input bit clr);
        drive(v, ch, d, ord, clr);
        half();
        tick();
    endtask

    initial begin
        logic [DW-1:0] seq_d [4];
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        // Reset held for 100 cycles, outputs checked while asserted.
        repeat (99) @(posedge clk);
        half();
        chk("rst_out_ch", out_ch, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        half();
        chk("rel_af", almost_full, 4'b0000);
        chk("rel_out_ch", out_ch, 0);
        tick();

        // Fill ch2, attempt a fifth write, then drain in order.
        seq_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, 2, seq_d[i], 0, 0);
        drive(1, 2, 8'h55, 0, 0);
        half();
        chk("full_in_ready", in_ready, 0);
        chk("full_count2", cnt_of(2), 4);
        chk("full_af2", almost_full[2], 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            half();
            chk("drain_data", out_data, seq_d[i]);
            chk("drain_ch", out_ch, 2);
            tick();
        end

        // One entry per channel, read back round-robin one per cycle.
        for (int c = 0; c < NCH; c++) step(1, c, 8'hA0 + c, 0, 0);
        for (int c = 0; c < NCH; c++) begin
            drive(0, 0, 0, 1, 0);
            half();
            chk("rr_valid", out_valid, 1);
            chk("rr_ch", out_ch, c);
            chk("rr_data", out_data, 8'hA0 + c);
            tick();
        end

        // Stalled grant on ch3 must hold while ch0 becomes non-empty.
        step(1, 3, 8'hC3, 0, 0);
        drive(1, 0, 8'hC0, 0, 0);
        half();
        chk("lock_ch", out_ch, 3);
        chk("lock_data", out_data, 8'hC3);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            half();
            chk("lock_ch", out_ch, 3);
            chk("lock_data", out_data, 8'hC3);
            tick();
        end
        drive(0, 0, 0, 1, 0);
        half();
        chk("lock_accept_ch", out_ch, 3);
        tick();
        drive(0, 0, 0, 1, 0);
        half();
        chk("after_lock_ch", out_ch, 0);
        chk("after_lock_data", out_data, 8'hC0);
        tick();

        // Simultaneous write and read on ch1 keeps count and order.
        step(1, 1, 8'h51, 0, 0);
        step(1, 1, 8'h52, 0, 0);
        drive(1, 1, 8'h77, 1, 0);
        half();
        chk("sim_data", out_data, 8'h51);
        tick();
        drive(0, 0, 0, 1, 0);
        half();
        chk("sim_count1", cnt_of(1), 2);
        chk("sim_data2", out_data, 8'h52);
        tick();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Partially fill all channels, then clear alongside a write and a read.
        step(1, 0, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h03, 0, 0);
        step(1, 2, 8'h04, 0, 0);
        step(1, 3, 8'h05, 0, 0);
        step(1, 0, 8'hEE, 1, 1);
        drive(0, 0, 0, 0, 0);
        half();
        chk("clr_count", count, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_ready", in_ready, 1);
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 3), $urandom_range(0, 255),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset in the middle of a transfer discards everything.
        step(1, 0, 8'h0A, 0, 0);
        step(1, 1, 8'h0B, 0, 0);
        drive(1, 2, 8'h0C, 1, 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_af", almost_full, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_out_ch", out_ch, 0);
        model_reset();
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        half();
        tick();
        step(1, 3, 8'h5A, 0, 0);
        drive(0, 0, 0, 1, 0);
        half();
        chk("post_rst_data", out_data, 8'h5A);
        tick();
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jh_mc_reg_fifo.md
JH_MC_REG_FIFO -- requirements
Module: jh_mc_reg_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per entry.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per channel; power of two, >= 2.
REQ-003 SHALL have parameter NUM_CH, default 4, independent channels; >= 2.
REQ-004 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, almost-full threshold; 1..FIFO_DEPTH.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, write payload.
REQ-008 SHALL have port in_ch, input, $clog2(NUM_CH), target channel of the write.
REQ-009 SHALL have port in_valid, input, 1, write request.
REQ-010 SHALL have port in_ready, output, 1, high when channel in_ch is not full.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, head entry of the granted channel.
REQ-012 SHALL have port out_ch, output, $clog2(NUM_CH), granted channel index.
REQ-013 SHALL have port out_valid, output, 1, granted channel is non-empty.
REQ-014 SHALL have port out_ready, input, 1, read accept.
REQ-015 SHALL have port clear, input, 1, synchronous flush of all channels.
REQ-016 SHALL have port count, output, NUM_CH*($clog2(FIFO_DEPTH)+1), packed per-channel occupancy; channel c in slice c.
REQ-017 SHALL have port almost_full, output, NUM_CH, per-channel flag count[c] >= AF_LEVEL.

Function
REQ-018 A write SHALL occur when in_valid && in_ready; the entry is appended to channel in_ch at the rising edge.
REQ-019 in_ready SHALL be combinational from in_ch and registered occupancy: low only when channel in_ch holds FIFO_DEPTH entries.
REQ-020 Write-to-read latency SHALL be one cycle: an entry written at edge N is eligible for out_valid from edge N onward.
REQ-021 A read SHALL occur when out_valid && out_ready; the granted channel's head is popped at the rising edge.
REQ-022 Arbiter SHALL be round-robin: grant is the first non-empty channel at or after rr_ptr, scanning upward with wrap from NUM_CH-1 to 0.
REQ-023 After a read from channel g, rr_ptr SHALL become (g+1) mod NUM_CH.
REQ-024 While out_valid && !out_ready, grant, out_ch and out_data SHALL stay locked until the read completes, even if a lower-index-after-rr_ptr channel becomes non-empty.
REQ-025 out_valid SHALL be low when all channels are empty; out_data is then don't-care.
REQ-026 Simultaneous write and read on the same channel SHALL leave its count unchanged and preserve FIFO order; on different channels each count moves independently.
REQ-027 A write to a full channel SHALL have no effect.
REQ-028 Each channel's read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap naturally; count SHALL be $clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
REQ-029 clear SHALL take priority over same-cycle writes and reads: all counts become 0, pointers 0, rr_ptr 0, lock released; in_ready high and out_valid low the next cycle.
REQ-030 almost_full[c] SHALL be derived from registered count only.

Reset
REQ-031 On rstn low, all counts, pointers, rr_ptr and the grant lock SHALL clear immediately, independent of clk.
REQ-032 During and after reset: out_valid=0, count=0, almost_full=0, in_ready=1, out_ch=0.
REQ-033 Reset asserted mid-transfer SHALL discard all stored entries; storage array contents need no reset.

Structure
REQ-034 Package jh_fifo_pkg SHALL hold default constants (DATA_WIDTH, FIFO_DEPTH, NUM_CH) and a count-width function $clog2(depth)+1.
REQ-035 Per-channel storage SHALL be sub-module jh_reg_fifo_lane (single-channel register FIFO with push, pop, clear, count, full, empty, head), instantiated NUM_CH times in a generate loop.
REQ-036 The round-robin arbiter and lock SHALL live in the top module.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4, NUM_CH=4, AF_LEVEL=3)
REQ-037 Reset 100 cycles, release -> in_ready=1, out_valid=0, all counts 0, almost_full=0000.
REQ-038 Write 0x11,0x22,0x33,0x44 to ch2, then a fifth write 0x55 -> in_ready=0 on the fifth, count[2]=4, almost_full[2]=1; read all -> 0x11..0x44 in order, out_ch=2.
REQ-039 One entry each in ch0..ch3 (0xA0..0xA3), out_ready=1 -> reads in order ch0,ch1,ch2,ch3, one per cycle.
REQ-040 Entry in ch3 (0xC3), out_ready=0 for 3 cycles, write 0xC0 to ch0 meanwhile -> out_ch stays 3, out_data stays 0xC3 until accepted; next read is ch0.
REQ-041 ch1 holds 2 entries; simultaneous write 0x77 ch1 and read ch1 -> count[1] stays 2, order preserved.
REQ-042 All channels partially filled, clear with in_valid=1 and out_ready=1 -> next cycle all counts 0, out_valid=0, written entry dropped.
